// File: rtl/layer_fetch_sequencer.sv
// Read initiator for one dense-layer pass: programs per-neuron weight/bias pointers,
// then streams x[i], w_k[i] and b_k from memory to the MAC array under ready/valid backpressure.
module layer_fetch_sequencer #(
  parameter int N_NEURON = 10,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32
) (
  input  logic                         clock_mem,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_W-1:0]            n_in,
  input  logic [ADDR_W-1:0]            x_base,
  input  logic [ADDR_W-1:0]            w_base,
  input  logic [ADDR_W-1:0]            b_base,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_en,
  output logic [ADDR_W-1:0]            x_addr,
  output logic [N_NEURON*ADDR_W-1:0]   w_addr_bus,
  output logic [N_NEURON*ADDR_W-1:0]   b_addr_bus,
  input  logic [DATA_W-1:0]            x_data,
  input  logic [N_NEURON*DATA_W-1:0]   w_data_bus,
  input  logic [N_NEURON*DATA_W-1:0]   b_data_bus,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_x,
  output logic [N_NEURON*DATA_W-1:0]   out_w,
  output logic [N_NEURON*DATA_W-1:0]   out_b,
  output logic                         out_first,
  output logic                         out_last
);

  localparam int K_W = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
  localparam logic [K_W-1:0]    K_LAST = K_W'(N_NEURON - 1);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_FETCH, S_DRAIN} state_t;

  state_t state_q, state_d;

  logic [ADDR_W-1:0] n_in_q, x_base_q, b_base_q, row_ptr_q, i_q;
  logic [K_W-1:0]    k_q;
  logic [ADDR_W-1:0] x_addr_p0;
  logic [ADDR_W-1:0] w_addr_p0 [N_NEURON];
  logic [ADDR_W-1:0] b_addr_p0 [N_NEURON];
  logic              vld_p1, first_p1, last_p1;
  logic              busy_q, done_q;

  logic init_last, issue, last_issue, drain_done;

  always_comb begin
    init_last  = (state_q == S_INIT) && (k_q == K_LAST);
    issue      = (state_q == S_FETCH) && (i_q < n_in_q) && (!vld_p1 || out_ready);
    last_issue = issue && (i_q == (n_in_q - ONE));
    drain_done = (state_q == S_DRAIN) && vld_p1 && out_ready;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_INIT;
      S_INIT:  if (init_last) state_d = (n_in_q == '0) ? S_IDLE : S_FETCH;
      S_FETCH: if (last_issue) state_d = S_DRAIN;
      S_DRAIN: if (drain_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_mem or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Control: pass parameters, counters, handshake flags
  always_ff @(posedge clock_mem or negedge rst_n) begin
    if (!rst_n) begin
      n_in_q    <= '0;
      x_base_q  <= '0;
      b_base_q  <= '0;
      row_ptr_q <= '0;
      i_q       <= '0;
      k_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      vld_p1    <= 1'b0;
      first_p1  <= 1'b0;
      last_p1   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            n_in_q    <= n_in;
            x_base_q  <= x_base;
            b_base_q  <= b_base;
            row_ptr_q <= w_base;
            k_q       <= '0;
            busy_q    <= 1'b1;
          end
        end
        S_INIT: begin
          row_ptr_q <= row_ptr_q + n_in_q;
          k_q       <= k_q + 1'b1;
          if (init_last) begin
            i_q <= '0;
            if (n_in_q == '0) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (issue) begin
            vld_p1   <= 1'b1;
            first_p1 <= (i_q == '0);
            last_p1  <= (i_q == (n_in_q - ONE));
            i_q      <= i_q + ONE;
          end else if (vld_p1 && out_ready) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (drain_done) begin
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Address stage p0: pointers presented to memory; read data appears one edge later (p1)
  always_ff @(posedge clock_mem or negedge rst_n) begin
    if (!rst_n) begin
      x_addr_p0 <= '0;
      for (int k = 0; k < N_NEURON; k++) begin
        w_addr_p0[k] <= '0;
        b_addr_p0[k] <= '0;
      end
    end else if (state_q == S_INIT) begin
      w_addr_p0[k_q] <= row_ptr_q;
      b_addr_p0[k_q] <= b_base_q + ADDR_W'(k_q);
      if (init_last) x_addr_p0 <= x_base_q;
    end else if (issue) begin
      x_addr_p0 <= x_addr_p0 + ONE;
      for (int k = 0; k < N_NEURON; k++) w_addr_p0[k] <= w_addr_p0[k] + ONE;
    end
  end

  for (genvar g = 0; g < N_NEURON; g++) begin : g_addr_bus
    assign w_addr_bus[g*ADDR_W +: ADDR_W] = w_addr_p0[g];
    assign b_addr_bus[g*ADDR_W +: ADDR_W] = b_addr_p0[g];
  end

  assign rd_en     = issue;
  assign x_addr    = x_addr_p0;
  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = vld_p1;
  assign out_first = first_p1;
  assign out_last  = last_p1;
  // Memory holds its output while rd_en is low, so data needs no local buffering
  assign out_x     = x_data;
  assign out_w     = w_data_bus;
  assign out_b     = b_data_bus;

endmodule

// File: tb/tb_layer_fetch_sequencer.sv
// Bench for layer_fetch_sequencer: table of layer passes checked against a scoreboard
// fed from a behavioural memory, plus hand-written abort / ignored-start sequences.
module tb_layer_fetch_sequencer;

  localparam int NN = 10;
  localparam int AW = 16;
  localparam int DW = 32;

  logic              clock_mem = 1'b0;
  logic              rst_n     = 1'b0;
  logic              start     = 1'b0;
  logic [AW-1:0]     n_in = '0, x_base = '0, w_base = '0, b_base = '0;
  logic              busy, done, rd_en, out_valid, out_first, out_last;
  logic [AW-1:0]     x_addr;
  logic [NN*AW-1:0]  w_addr_bus, b_addr_bus;
  logic [DW-1:0]     x_data = '0;
  logic [NN*DW-1:0]  w_data_bus = '0, b_data_bus = '0;
  logic              out_ready = 1'b1;
  logic [DW-1:0]     out_x;
  logic [NN*DW-1:0]  out_w, out_b;

  layer_fetch_sequencer #(.N_NEURON(NN), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock_mem(clock_mem), .rst_n(rst_n), .start(start), .n_in(n_in),
    .x_base(x_base), .w_base(w_base), .b_base(b_base),
    .busy(busy), .done(done), .rd_en(rd_en), .x_addr(x_addr),
    .w_addr_bus(w_addr_bus), .b_addr_bus(b_addr_bus),
    .x_data(x_data), .w_data_bus(w_data_bus), .b_data_bus(b_data_bus),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_w(out_w), .out_b(out_b), .out_first(out_first), .out_last(out_last)
  );

  always #5 clock_mem = ~clock_mem;

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return {a ^ 16'hC3A5, a};
  endfunction

  // Behavioural memory: registered read, holds data while rd_en is low
  always @(posedge clock_mem) begin
    if (rd_en) begin
      x_data <= memf(x_addr);
      for (int k = 0; k < NN; k++) begin
        w_data_bus[k*DW +: DW] <= memf(w_addr_bus[k*AW +: AW]);
        b_data_bus[k*DW +: DW] <= memf(b_addr_bus[k*AW +: AW]);
      end
    end
  end

  typedef struct {
    logic [DW-1:0]    x;
    logic [NN*DW-1:0] w;
    logic [NN*DW-1:0] b;
    logic             first;
    logic             last;
  } elem_t;

  typedef struct {
    logic [AW-1:0] n;
    logic [AW-1:0] xb;
    logic [AW-1:0] wb;
    logic [AW-1:0] bb;
    int            stall;
    int            exp_done;
  } vec_t;

  elem_t sb[$];
  vec_t  vecs[5];
  int    comps = 0;
  int    fails = 0;

  task automatic chk(input bit ok, input string name, input string detail);
    comps++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic bit outs_zero();
    return ({busy, done, rd_en, out_valid, out_first, out_last, x_addr, w_addr_bus, b_addr_bus} === '0);
  endfunction

  task automatic run_pass(input vec_t v);
    elem_t         e, got;
    int            cyc, nrd, nhs, first_rd, last_hs, done_cyc, stall_left, stall_idx;
    bit            seen_v, any_valid;
    logic [DW-1:0] held_x;
    sb.delete();
    for (int j = 0; j < int'(v.n); j++) begin
      e.x = memf(AW'(int'(v.xb) + j));
      for (int k = 0; k < NN; k++) begin
        e.w[k*DW +: DW] = memf(AW'(int'(v.wb) + k*int'(v.n) + j));
        e.b[k*DW +: DW] = memf(AW'(int'(v.bb) + k));
      end
      e.first = (j == 0);
      e.last  = (j == int'(v.n) - 1);
      sb.push_back(e);
    end
    @(negedge clock_mem);
    n_in = v.n; x_base = v.xb; w_base = v.wb; b_base = v.bb;
    start = 1'b1; out_ready = 1'b1;
    @(posedge clock_mem);
    #1 start = 1'b0;
    cyc = 0; nrd = 0; nhs = 0; first_rd = -1; last_hs = -1; done_cyc = -1;
    stall_left = 0; stall_idx = 0; seen_v = 0; any_valid = 0; held_x = '0;
    while (cyc < 400 && done_cyc < 0) begin
      out_ready = (stall_left == 0);
      @(negedge clock_mem);
      if (cyc == 0) chk(busy === 1'b1, "busy_rise", $sformatf("got %b want 1", busy));
      if (out_valid) any_valid = 1;
      if (!out_ready) begin
        chk(rd_en === 1'b0, "stall_rd_en", $sformatf("cycle %0d got %b want 0", cyc, rd_en));
        if (stall_idx == 0) held_x = out_x;
        else chk(out_x === held_x, "stall_out_x", $sformatf("got %h want %h", out_x, held_x));
        stall_idx++;
        stall_left--;
      end
      if (rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        chk(x_addr === AW'(int'(v.xb) + nrd), "x_addr",
            $sformatf("read %0d got %h want %h", nrd, x_addr, AW'(int'(v.xb) + nrd)));
        chk(w_addr_bus[(NN-1)*AW +: AW] === AW'(int'(v.wb) + (NN-1)*int'(v.n) + nrd), "w10_addr",
            $sformatf("read %0d got %h want %h", nrd, w_addr_bus[(NN-1)*AW +: AW],
                      AW'(int'(v.wb) + (NN-1)*int'(v.n) + nrd)));
        chk(b_addr_bus[2*AW +: AW] === AW'(int'(v.bb) + 2), "b3_addr",
            $sformatf("got %h want %h", b_addr_bus[2*AW +: AW], AW'(int'(v.bb) + 2)));
        nrd++;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk(1'b0, "sb_underflow", $sformatf("extra element x=%h", out_x));
        end else begin
          got = sb.pop_front();
          chk(out_x === got.x && out_w === got.w, "elem_data",
              $sformatf("elem %0d x got %h want %h w got %h want %h", nhs, out_x, got.x, out_w, got.w));
          chk(out_b === got.b, "elem_bias", $sformatf("elem %0d got %h want %h", nhs, out_b, got.b));
          chk({out_first, out_last} === {got.first, got.last}, "elem_flags",
              $sformatf("elem %0d got %b%b want %b%b", nhs, out_first, out_last, got.first, got.last));
        end
        nhs++;
        last_hs = cyc;
        if (!seen_v && v.stall > 0) stall_left = v.stall;
        seen_v = 1;
      end
      if (done) begin
        done_cyc = cyc;
        chk(busy === 1'b0, "busy_fall", $sformatf("got %b want 0", busy));
      end
      @(posedge clock_mem);
      #1 cyc++;
    end
    out_ready = 1'b1;
    chk(done_cyc == v.exp_done, "done_cycle", $sformatf("got %0d want %0d", done_cyc, v.exp_done));
    chk(nrd == int'(v.n), "rd_count", $sformatf("got %0d want %0d", nrd, v.n));
    chk(nhs == int'(v.n), "handshakes", $sformatf("got %0d want %0d", nhs, v.n));
    chk(sb.size() == 0, "sb_empty", $sformatf("got %0d left want 0", sb.size()));
    if (v.n != 0) begin
      chk(first_rd == 10, "first_rd", $sformatf("got %0d want 10", first_rd));
      chk(done_cyc == last_hs + 1, "done_after_hs", $sformatf("got %0d want %0d", done_cyc, last_hs + 1));
    end else begin
      chk(!any_valid, "no_valid", $sformatf("got %b want 0", any_valid));
    end
    @(negedge clock_mem);
    chk(done === 1'b0 && out_valid === 1'b0, "done_pulse",
        $sformatf("done %b out_valid %b want 0 0", done, out_valid));
  endtask

  initial begin
    bit idle_ok;
    vecs[0] = '{16'd4, 16'h0100, 16'h0200, 16'h0300, 0, 15};
    vecs[1] = '{16'd3, 16'h1000, 16'h2000, 16'h3000, 5, 19};
    vecs[2] = '{16'd0, 16'h0100, 16'h0200, 16'h0300, 0, 10};
    vecs[3] = '{16'd3, 16'hFFFE, 16'h4000, 16'h5000, 0, 14};
    vecs[4] = '{16'd1, 16'h0040, 16'hFFF0, 16'hFFFC, 0, 12};

    #2 chk(outs_zero(), "reset_state", $sformatf("busy %b done %b rd_en %b x_addr %h", busy, done, rd_en, x_addr));
    repeat (2) @(posedge clock_mem);
    @(negedge clock_mem) rst_n = 1'b1;
    @(negedge clock_mem);
    chk(outs_zero(), "post_reset_idle", $sformatf("busy %b rd_en %b x_addr %h", busy, rd_en, x_addr));

    for (int t = 0; t < 5; t++) run_pass(vecs[t]);

    // Abort mid-FETCH, with a start pulse while busy that must be ignored
    @(negedge clock_mem);
    n_in = 16'd8; x_base = 16'h0100; w_base = 16'h0200; b_base = 16'h0300;
    start = 1'b1; out_ready = 1'b1;
    @(posedge clock_mem);
    #1 start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clock_mem);
      #1;
    end
    @(negedge clock_mem);
    chk(rd_en === 1'b1 && x_addr === 16'h0102, "fetch_progress", $sformatf("rd_en %b x_addr %h want 1 0102", rd_en, x_addr));
    start = 1'b1; n_in = 16'd2; x_base = 16'h7000;
    @(posedge clock_mem);
    #1 start = 1'b0;
    @(negedge clock_mem);
    chk(rd_en === 1'b1 && x_addr === 16'h0103 && busy === 1'b1, "start_ignored",
        $sformatf("rd_en %b x_addr %h busy %b want 1 0103 1", rd_en, x_addr, busy));
    #2 rst_n = 1'b0;
    #1 chk(outs_zero(), "async_abort", $sformatf("busy %b out_valid %b rd_en %b x_addr %h", busy, out_valid, rd_en, x_addr));
    idle_ok = 1;
    repeat (3) begin
      @(negedge clock_mem);
      if (done !== 1'b0 || busy !== 1'b0) idle_ok = 0;
    end
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clock_mem);
      if (done !== 1'b0 || rd_en !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) idle_ok = 0;
    end
    chk(idle_ok, "no_done_after_abort", $sformatf("done %b rd_en %b busy %b", done, rd_en, busy));

    run_pass(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", comps, fails);
    $finish;
  end

endmodule
